lcd_ctrl: RTL and testbench

HD44780-compatible character-LCD bus controller. It runs the LCD power-on/init command sequence, then writes two 16-character lines by pulling characters one at a time from the line-text character source through a one-cycle request strobe. It sits between the character source and the LCD pins, and owns LCD_E/RS/RW/DATA timing.

---
 rtl/lcd_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_lcd_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_ctrl.sv
// lcd_ctrl -- HD44780-compatible character-LCD bus controller.
// Runs the power-on init sequence, then writes two 16-character lines,
// fetching each character from an external source via a one-cycle strobe.
// Optional feature: define LCD_REFRESH_EN to keep rewriting both lines
// forever instead of stopping in DONE after the first pass.
module lcd_ctrl #(
    parameter int CLK_DIV    = 4,
    parameter int INIT_WAIT  = 70,
    parameter int CLEAR_WAIT = 20
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic [7:0] CHAR_DATA,
    output logic       CHAR_REQ,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [7:0] LCD_DATA,
    output logic       LINE,
    output logic [3:0] COL,
    output logic       BUSY
);

    localparam int CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int WAIT_MAX = (INIT_WAIT > CLEAR_WAIT) ? INIT_WAIT : CLEAR_WAIT;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

    typedef enum logic [3:0] {
        S_WAIT_PWR,
        S_FUNC_SET,
        S_DISP_ON,
        S_ENTRY,
        S_CLEAR,
        S_WAIT_CLR,
        S_L1_ADDR,
        S_L1_DATA,
        S_L2_ADDR,
        S_L2_DATA,
        S_DONE
    } state_t;

    // Every bus write walks setup (E low), strobe (E high), hold (E low).
    typedef enum logic [1:0] {
        PH_SETUP,
        PH_STROBE,
        PH_HOLD
    } phase_t;

    logic [CNT_W-1:0]  r_tickCnt;
    logic [WAIT_W-1:0] r_waitCnt;
    state_t            r_state;
    phase_t            r_phase;
    logic              r_e;
    logic              r_rs;
    logic [7:0]        r_data;
    logic              r_charReq;
    logic              r_line;
    logic [3:0]        r_col;
    logic              r_busy;
    logic              w_tick;
    logic              w_isData;
    logic              w_capture;

    assign w_tick    = (r_tickCnt == CNT_W'(CLK_DIV - 1));
    assign w_isData  = (r_state == S_L1_DATA) || (r_state == S_L2_DATA);
    // Character arrives a few cycles after the request; latch it on the
    // last clock of the setup phase so it is on the bus when E rises.
    assign w_capture = w_isData && (r_phase == PH_SETUP) &&
                       (r_tickCnt == CNT_W'(CLK_DIV - 2));

    // Free-running divider producing one LCD tick every CLK_DIV clocks.
    always_ff @(posedge CLK or posedge RESETN) begin
        if (RESETN) begin
            r_tickCnt <= '0;
        end else if (w_tick) begin
            r_tickCnt <= '0;
        end else begin
            r_tickCnt <= r_tickCnt + 1'b1;
        end
    end

    // Sequencer: init waits and commands, then line address and data writes.
    always_ff @(posedge CLK or posedge RESETN) begin
        if (RESETN) begin
            r_state   <= S_WAIT_PWR;
            r_phase   <= PH_SETUP;
            r_waitCnt <= '0;
            r_e       <= 1'b0;
            r_rs      <= 1'b0;
            r_data    <= 8'h00;
            r_charReq <= 1'b0;
            r_line    <= 1'b0;
            r_col     <= 4'd0;
            r_busy    <= 1'b1;
        end else begin
            r_charReq <= 1'b0;
            if (w_capture) begin
                r_data <= CHAR_DATA;
            end
            if (w_tick) begin
                case (r_state)
                    S_WAIT_PWR: begin
                        if (r_waitCnt == WAIT_W'(INIT_WAIT - 1)) begin
                            r_waitCnt <= '0;
                            r_state   <= S_FUNC_SET;
                            r_phase   <= PH_SETUP;
                            r_rs      <= 1'b0;
                            r_data    <= 8'h38;
                        end else begin
                            r_waitCnt <= r_waitCnt + 1'b1;
                        end
                    end
                    S_WAIT_CLR: begin
                        if (r_waitCnt == WAIT_W'(CLEAR_WAIT - 1)) begin
                            r_waitCnt <= '0;
                            r_state   <= S_L1_ADDR;
                            r_phase   <= PH_SETUP;
                            r_rs      <= 1'b0;
                            r_data    <= 8'h80;
                        end else begin
                            r_waitCnt <= r_waitCnt + 1'b1;
                        end
                    end
                    S_DONE: begin
                        r_busy <= 1'b0;
                    end
                    default: begin
                        case (r_phase)
                            PH_SETUP: begin
                                r_e     <= 1'b1;
                                r_phase <= PH_STROBE;
                            end
                            PH_STROBE: begin
                                r_e     <= 1'b0;
                                r_phase <= PH_HOLD;
                            end
                            default: begin
                                r_phase <= PH_SETUP;
                                case (r_state)
                                    S_FUNC_SET: begin
                                        r_state <= S_DISP_ON;
                                        r_data  <= 8'h0C;
                                    end
                                    S_DISP_ON: begin
                                        r_state <= S_ENTRY;
                                        r_data  <= 8'h06;
                                    end
                                    S_ENTRY: begin
                                        r_state <= S_CLEAR;
                                        r_data  <= 8'h01;
                                    end
                                    S_CLEAR: begin
                                        r_state   <= S_WAIT_CLR;
                                        r_waitCnt <= '0;
                                    end
                                    S_L1_ADDR: begin
                                        r_state   <= S_L1_DATA;
                                        r_rs      <= 1'b1;
                                        r_charReq <= 1'b1;
                                    end
                                    S_L1_DATA: begin
                                        if (r_col == 4'd15) begin
                                            r_col   <= 4'd0;
                                            r_state <= S_L2_ADDR;
                                            r_rs    <= 1'b0;
                                            r_data  <= 8'hC0;
                                            r_line  <= 1'b1;
                                        end else begin
                                            r_col     <= r_col + 4'd1;
                                            r_charReq <= 1'b1;
                                        end
                                    end
                                    S_L2_ADDR: begin
                                        r_state   <= S_L2_DATA;
                                        r_rs      <= 1'b1;
                                        r_charReq <= 1'b1;
                                    end
                                    S_L2_DATA: begin
                                        if (r_col == 4'd15) begin
                                            r_col <= 4'd0;
`ifdef LCD_REFRESH_EN
                                            r_state <= S_L1_ADDR;
                                            r_rs    <= 1'b0;
                                            r_data  <= 8'h80;
                                            r_line  <= 1'b0;
`else
                                            r_state <= S_DONE;
                                            r_busy  <= 1'b0;
`endif
                                        end else begin
                                            r_col     <= r_col + 4'd1;
                                            r_charReq <= 1'b1;
                                        end
                                    end
                                    default: begin
                                        r_state <= S_WAIT_PWR;
                                    end
                                endcase
                            end
                        endcase
                    end
                endcase
            end
        end
    end

    assign CHAR_REQ = r_charReq;
    assign LCD_E    = r_e;
    assign LCD_RS   = r_rs;
    assign LCD_RW   = 1'b0;
    assign LCD_DATA = r_data;
    assign LINE     = r_line;
    assign COL      = r_col;
    assign BUSY     = r_busy;

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl -- scoreboard bench for lcd_ctrl.
// The main process issues resets and pushes the expected LCD write stream
// (built from the command list and the text the source will hand out);
// a negedge monitor pops one entry per E fall and checks bytes and timing.
// Build with LCD_REFRESH_EN defined to exercise the refresh variant.
module tb_lcd_ctrl;

    localparam int CLK_DIV    = 4;
    localparam int INIT_WAIT  = 70;
    localparam int CLEAR_WAIT = 20;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        logic       isData;
        logic       line;
        logic [3:0] col;
        int         gap;
    } wr_t;

    logic       CLK;
    logic       RESETN;
    logic [7:0] CHAR_DATA;
    logic       CHAR_REQ;
    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;
    logic [7:0] LCD_DATA;
    logic       LINE;
    logic [3:0] COL;
    logic       BUSY;

    wr_t        expQ[$];
    wr_t        cur;
    logic [7:0] text[64];
    int         errors;
    int         checks;
    int         cycCnt;
    int         srcIdx;
    int         srcWin;
    int         reqCnt;
    int         riseCnt;
    int         lastRise;
    int         eHigh;
    int         rsStable;
    int         dataStable;
    int         holdLeft;
    bit         holdOk;
    logic       holdRs;
    logic [7:0] holdData;
    logic       prevE;
    logic       prevReq;
    logic       prevRs;
    logic [7:0] prevData;
    bit         monEn;

    lcd_ctrl #(
        .CLK_DIV    (CLK_DIV),
        .INIT_WAIT  (INIT_WAIT),
        .CLEAR_WAIT (CLEAR_WAIT)
    ) dut (
        .CLK       (CLK),
        .RESETN    (RESETN),
        .CHAR_DATA (CHAR_DATA),
        .CHAR_REQ  (CHAR_REQ),
        .LCD_E     (LCD_E),
        .LCD_RS    (LCD_RS),
        .LCD_RW    (LCD_RW),
        .LCD_DATA  (LCD_DATA),
        .LINE      (LINE),
        .COL       (COL),
        .BUSY      (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Clock edges since the last reset release; E rises are timed from here.
    always @(posedge CLK or posedge RESETN) begin
        if (RESETN) cycCnt <= 0;
        else        cycCnt <= cycCnt + 1;
    end

    // Character source: answers each request with the next text byte, keeps
    // it valid for a short window, then puts junk on the bus.
    always @(posedge CLK or posedge RESETN) begin
        if (RESETN) begin
            srcIdx    <= 0;
            srcWin    <= 0;
            CHAR_DATA <= 8'h00;
        end else if (CHAR_REQ) begin
            CHAR_DATA <= text[srcIdx % 64];
            srcIdx    <= srcIdx + 1;
            srcWin    <= CLK_DIV - 2;
        end else if (srcWin > 0) begin
            srcWin <= srcWin - 1;
        end else begin
            CHAR_DATA <= 8'($urandom);
        end
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic pushWr(input logic rs, input logic [7:0] data, input logic isData,
                          input logic line, input int col, input int gap);
        wr_t w;
        w.rs     = rs;
        w.data   = data;
        w.isData = isData;
        w.line   = line;
        w.col    = 4'(col);
        w.gap    = gap;
        expQ.push_back(w);
    endtask

    // Expected writes for one display pass; textBase selects which 32 source
    // bytes it carries, withInit prepends the power-on command sequence.
    task automatic pushPass(input int textBase, input bit withInit);
        if (withInit) begin
            pushWr(1'b0, 8'h38, 1'b0, 1'b0, 0, (INIT_WAIT + 1) * CLK_DIV);
            pushWr(1'b0, 8'h0C, 1'b0, 1'b0, 0, 3 * CLK_DIV);
            pushWr(1'b0, 8'h06, 1'b0, 1'b0, 0, 3 * CLK_DIV);
            pushWr(1'b0, 8'h01, 1'b0, 1'b0, 0, 3 * CLK_DIV);
            pushWr(1'b0, 8'h80, 1'b0, 1'b0, 0, (3 + CLEAR_WAIT) * CLK_DIV);
        end else begin
            pushWr(1'b0, 8'h80, 1'b0, 1'b0, 0, 3 * CLK_DIV);
        end
        for (int i = 0; i < 16; i++) pushWr(1'b1, text[textBase + i], 1'b1, 1'b0, i, 3 * CLK_DIV);
        pushWr(1'b0, 8'hC0, 1'b0, 1'b1, 0, 3 * CLK_DIV);
        for (int i = 0; i < 16; i++) pushWr(1'b1, text[textBase + 16 + i], 1'b1, 1'b1, i, 3 * CLK_DIV);
    endtask

    // Hold reset briefly, load the expected stream, release between edges.
    task automatic applyStimulus();
        @(negedge CLK);
        #1 RESETN = 1'b1;
        repeat (3) @(negedge CLK);
        expQ.delete();
        pushPass(0, 1'b1);
        monEn = 1'b1;
        #1 RESETN = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_e"},    LCD_E,    0);
        checkOutput({tag, "_rs"},   LCD_RS,   0);
        checkOutput({tag, "_rw"},   LCD_RW,   0);
        checkOutput({tag, "_data"}, LCD_DATA, 0);
        checkOutput({tag, "_req"},  CHAR_REQ, 0);
        checkOutput({tag, "_line"}, LINE,     0);
        checkOutput({tag, "_col"},  COL,      0);
        checkOutput({tag, "_busy"}, BUSY,     1);
    endtask

    task automatic waitDrain(input string tag);
        for (int i = 0; i < 8000; i++) begin
            @(negedge CLK);
            if (expQ.size() == 0) break;
        end
        checkOutput({tag, "_drained"}, expQ.size(), 0);
    endtask

    // Monitor: E timing, setup/hold stability, request placement, scoreboard.
    always @(negedge CLK) begin
        if (RESETN) begin
            prevE    = 1'b0;
            prevReq  = 1'b0;
            prevRs   = LCD_RS;
            prevData = LCD_DATA;
            rsStable = 0;
            dataStable = 0;
            lastRise = 0;
            eHigh    = 0;
            holdLeft = 0;
            reqCnt   = 0;
        end else if (monEn) begin
            rsStable   = (LCD_RS === prevRs)     ? rsStable + 1   : 0;
            dataStable = (LCD_DATA === prevData) ? dataStable + 1 : 0;
            if (holdLeft > 0) begin
                if (LCD_RS !== holdRs || LCD_DATA !== holdData) holdOk = 1'b0;
                holdLeft--;
                if (holdLeft == 0) checkOutput("hold_after_fall", holdOk, 1);
            end
            if (CHAR_REQ) begin
                reqCnt++;
                checkOutput("req_pulse_width", prevReq, 0);
                checkOutput("req_in_data_slot", (expQ.size() > 0 && expQ[0].isData) ? 1 : 0, 1);
            end
            if (LCD_E && !prevE) begin
                riseCnt++;
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_write", LCD_E, 0);
                end else begin
                    checkOutput("rise_gap", cycCnt - lastRise, expQ[0].gap);
                    checkOutput("rs_setup", (rsStable >= CLK_DIV) ? 1 : 0, 1);
                    if (!expQ[0].isData) checkOutput("data_setup", (dataStable >= CLK_DIV) ? 1 : 0, 1);
                end
                lastRise = cycCnt;
                eHigh    = 0;
            end
            if (LCD_E) eHigh++;
            if (!LCD_E && prevE && expQ.size() > 0) begin
                cur = expQ.pop_front();
                checkOutput("write_rs",   LCD_RS,   cur.rs);
                checkOutput("write_data", LCD_DATA, cur.data);
                checkOutput("e_width",    eHigh,    CLK_DIV);
                if (cur.isData) begin
                    checkOutput("write_line", LINE, cur.line);
                    checkOutput("write_col",  COL,  cur.col);
                end
                holdRs   = LCD_RS;
                holdData = LCD_DATA;
                holdOk   = 1'b1;
                holdLeft = CLK_DIV - 1;
            end
            prevE    = LCD_E;
            prevReq  = CHAR_REQ;
            prevRs   = LCD_RS;
            prevData = LCD_DATA;
        end
    end

    initial begin
        string s;
        int    snap;
        bit    found;
        RESETN  = 1'b1;
        monEn   = 1'b0;
        errors  = 0;
        checks  = 0;
        riseCnt = 0;
        s = "Connecting...   ";
        for (int i = 0; i < 16; i++) text[i] = s[i];
        for (int i = 16; i < 64; i++) text[i] = 8'($urandom_range(32, 126));

        repeat (4) @(negedge CLK);
        checkResetValues("por");

        applyStimulus();
`ifdef LCD_REFRESH_EN
        for (int i = 0; i < 8000; i++) begin
            @(negedge CLK);
            if (expQ.size() <= 16) break;
        end
        checkOutput("pass1_progress", (expQ.size() <= 16) ? 1 : 0, 1);
        pushPass(32, 1'b0);
        waitDrain("pass2");
        monEn = 1'b0;
        checkOutput("req_count_two_passes", reqCnt, 64);
        checkOutput("busy_refresh", BUSY, 1);
`else
        waitDrain("pass1");
        checkOutput("req_count", reqCnt, 32);
        repeat (3 * CLK_DIV) @(negedge CLK);
        checkOutput("done_busy", BUSY, 0);
        checkOutput("done_e", LCD_E, 0);
        checkOutput("done_req", CHAR_REQ, 0);
        snap = riseCnt;
        repeat (1000) @(negedge CLK);
        checkOutput("done_no_more_writes", riseCnt, snap);
        checkOutput("done_busy_held", BUSY, 0);
`endif

        // Reset while E is high on the sixth character of line 1.
        applyStimulus();
        found = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge CLK);
            if (LCD_E && LCD_RS && !LINE && COL == 4'd5) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("found_l1_col5", found, 1);
        #1 RESETN = 1'b1;
        #1 checkResetValues("midwrite");
        expQ.delete();

        applyStimulus();
        waitDrain("after_reset");
        monEn = 1'b0;
        checkOutput("req_count_after_reset", reqCnt, 32);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
